// File: rtl/freq_pkg.sv
// Shared definitions for the frequency sweep / generator / counter bench path:
// state encoding, 1 ms prescaler divisor, half-period clamp and default clock rate.
package freq_pkg;

  localparam int CLK_HZ_DEFAULT = 25_000_000;

  // Clamp arithmetic is done at this fixed width; half-period widths up to 32 bits are supported.
  localparam int HP_MAX_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_DWELL = S_DWELL,
    ST_DONE  = S_DONE
  } sweep_state_t;

  function automatic int ms_div(input int clk_hz);
    return (clk_hz < 1000) ? 1 : clk_hz / 1000;
  endfunction

  // Clamp a stepped half-period to the sweep end point; val carries two guard bits so it never wraps.
  function automatic logic [HP_MAX_W-1:0] hp_clamp(input logic signed [HP_MAX_W+1:0] val,
                                                   input logic [HP_MAX_W-1:0]        lim,
                                                   input logic                       down);
    logic signed [HP_MAX_W+1:0] lim_s;
    lim_s = signed'({2'b00, lim});
    if (down ? (val <= lim_s) : (val >= lim_s))
      return lim;
    else
      return val[HP_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms prescaler with synchronous clear. The clear cycle counts as the first cycle of a
// new millisecond, so the k-th tick lands exactly k*MS_DIV-1 cycles after the clear.
module ms_tick_gen
  import freq_pkg::*;
#(
  parameter int MS_DIV = 25_000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int CNT_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MS_DIV - 1);
  localparam logic [CNT_W-1:0] FIRST = (MS_DIV > 1) ? CNT_W'(1) : '0;

  logic [CNT_W-1:0] cnt;

  always_comb begin
    o_Tick = i_Clr ? (MS_DIV == 1) : (cnt == LAST);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      cnt <= '0;
    else if (i_Clr)
      cnt <= FIRST;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Linear half-period sweep sequencer for the square-wave generator, dwelling a programmable
// number of ms per point. Define FREQ_SWEEP_CTRL_LOOP_EN to repeat the sweep until aborted.
module freq_sweep_ctrl
  import freq_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int HP_W    = 24,
  parameter int DWELL_W = 16,
  parameter int IDX_W   = 16
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic               i_Abort,
  input  logic [HP_W-1:0]    i_Start_HP,
  input  logic [HP_W-1:0]    i_Stop_HP,
  input  logic [HP_W-1:0]    i_Step_HP,
  input  logic [DWELL_W-1:0] i_Dwell_Ms,
  output logic [HP_W-1:0]    o_Half_Period,
  output logic               o_Load,
  output logic               o_Gen_En,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Error,
  output logic [IDX_W-1:0]   o_Index
);

  localparam int MS_DIV = ms_div(CLK_HZ);

  sweep_state_t state;

  logic [HP_W-1:0]    stop_hp_l;
  logic [HP_W-1:0]    step_hp_l;
  logic [DWELL_W-1:0] dwell_m1_l;
  logic               down_l;
`ifdef FREQ_SWEEP_CTRL_LOOP_EN
  logic [HP_W-1:0]    start_hp_l;
`endif

  logic [DWELL_W-1:0] ms_cnt;
  logic [DWELL_W-1:0] ms_base;
  logic               tick;
  logic               expire;
  logic               at_stop;
  logic               start_ok;
  logic [HP_MAX_W-1:0]        cur_x;
  logic [HP_MAX_W-1:0]        step_x;
  logic [HP_MAX_W-1:0]        stop_x;
  logic signed [HP_MAX_W+1:0] sum_s;
  logic [HP_W-1:0]            next_hp;

  function automatic logic [IDX_W-1:0] idx_sat_inc(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ms_tick_gen #(
    .MS_DIV (MS_DIV)
  ) u_ms_tick (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clr   (o_Load),
    .o_Tick  (tick)
  );

  // The ms count restarts on each load cycle, including a tick that falls on it.
  always_comb begin
    ms_base  = o_Load ? '0 : ms_cnt;
    expire   = (state == ST_DWELL) && tick && (ms_base == dwell_m1_l);
    at_stop  = (o_Half_Period == stop_hp_l) || (step_hp_l == '0);
    start_ok = (state == ST_IDLE) && i_Start && !i_Abort &&
               (i_Start_HP != '0) && (i_Stop_HP != '0);
    cur_x    = HP_MAX_W'(o_Half_Period);
    step_x   = HP_MAX_W'(step_hp_l);
    stop_x   = HP_MAX_W'(stop_hp_l);
    sum_s    = down_l ? signed'({2'b00, cur_x}) - signed'({2'b00, step_x})
                      : signed'({2'b00, cur_x}) + signed'({2'b00, step_x});
    next_hp  = HP_W'(hp_clamp(sum_s, stop_x, down_l));
  end

  // Sweep configuration is captured once per accepted start and held for the whole sweep.
  always_ff @(posedge i_Clk) begin
    if (start_ok) begin
      stop_hp_l  <= i_Stop_HP;
      step_hp_l  <= i_Step_HP;
      dwell_m1_l <= (i_Dwell_Ms == '0) ? '0 : i_Dwell_Ms - 1'b1;
      down_l     <= (i_Stop_HP < i_Start_HP);
`ifdef FREQ_SWEEP_CTRL_LOOP_EN
      start_hp_l <= i_Start_HP;
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= ST_IDLE;
      o_Half_Period <= '0;
      o_Load        <= 1'b0;
      o_Gen_En      <= 1'b0;
      o_Busy        <= 1'b0;
      o_Done        <= 1'b0;
      o_Error       <= 1'b0;
      o_Index       <= '0;
      ms_cnt        <= '0;
    end else begin
      o_Load <= 1'b0;
      o_Done <= 1'b0;
      ms_cnt <= ms_base + DWELL_W'(tick);
      case (state)
        ST_IDLE: begin
          if (i_Start && !i_Abort) begin
            if ((i_Start_HP == '0) || (i_Stop_HP == '0)) begin
              o_Error <= 1'b1;
            end else begin
              o_Error       <= 1'b0;
              o_Half_Period <= i_Start_HP;
              o_Load        <= 1'b1;
              o_Gen_En      <= 1'b1;
              o_Busy        <= 1'b1;
              o_Index       <= '0;
              state         <= ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          if (i_Abort) begin
            state    <= ST_IDLE;
            o_Busy   <= 1'b0;
            o_Gen_En <= 1'b0;
          end else if (expire) begin
            if (at_stop) begin
`ifdef FREQ_SWEEP_CTRL_LOOP_EN
              o_Half_Period <= start_hp_l;
              o_Load        <= 1'b1;
              o_Index       <= '0;
`else
              state    <= ST_DONE;
              o_Done   <= 1'b1;
              o_Busy   <= 1'b0;
              o_Gen_En <= 1'b0;
`endif
            end else begin
              o_Half_Period <= next_hp;
              o_Load        <= 1'b1;
              o_Index       <= idx_sat_inc(o_Index);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_sweep_ctrl.md
Name: freq_sweep_ctrl

Overview:
Sequencer that drives a programmable square-wave generator through a linear sweep of half-period values, holding each point for a programmable dwell in milliseconds. It sits between the host/config registers and the generator, which takes a half-period count and a load strobe. It feeds the frequency counter's bench path. It provides start, abort and status handshakes, plus a point index for logging counter readings per step.

Parameters:
CLK_HZ, 25_000_000, system clock frequency; sets the 1 ms prescaler MS_DIV = CLK_HZ/1000.
HP_W, 24, width of half-period values in clock cycles.
DWELL_W, 16, width of dwell in ms.
IDX_W, 16, width of point index.

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Start  in  1  start sweep; sampled only in IDLE
i_Abort  in  1  stop sweep immediately
i_Start_HP  in  HP_W  first half-period (cycles, >=1)
i_Stop_HP  in  HP_W  last half-period (cycles, >=1)
i_Step_HP  in  HP_W  step magnitude; 0 = single point
i_Dwell_Ms  in  DWELL_W  dwell per point, ms; 0 treated as 1
o_Half_Period  out  HP_W  half-period to generator
o_Load  out  1  one-cycle strobe: generator latches o_Half_Period
o_Gen_En  out  1  generator enable
o_Busy  out  1  sweep in progress
o_Done  out  1  one-cycle pulse on normal completion
o_Error  out  1  sticky: last start rejected (Start_HP or Stop_HP = 0)
o_Index  out  IDX_W  current point number, 0-based

Behaviour:
- Reset: all outputs 0; state IDLE; prescaler and dwell counters 0.
- States: IDLE, DWELL, DONE. All outputs registered.
- IDLE + i_Start:
  - Start_HP or Stop_HP = 0: set o_Error and stay IDLE.
  - Otherwise: clear o_Error and latch Stop, Step and Dwell (inputs ignored until next start).
  - Next cycle: o_Half_Period=Start_HP, o_Load=1, o_Gen_En=1, o_Busy=1, o_Index=0, state DWELL.
- Direction: down if Stop_HP < Start_HP, else up; fixed for the sweep.
- DWELL:
  - Prescaler and ms counter restart on every o_Load cycle.
  - A point lasts exactly dwell*MS_DIV cycles, measured from its o_Load cycle to the next o_Load or o_Done cycle.
- Dwell expiry with current == Stop, or Step == 0: state DONE.
- Dwell expiry otherwise:
  - next = current ± Step, clamped to Stop on overshoot. Arithmetic is HP_W+1 bits so wrap cannot occur.
  - o_Load=1, o_Index+1, stay DWELL.
- DONE (one cycle): o_Done=1, o_Busy=0, o_Gen_En=0, o_Half_Period holds last value; then IDLE.
- o_Index saturates at all-ones.
- i_Abort in DWELL: next cycle IDLE, o_Busy=0, o_Gen_En=0, no o_Done, o_Load=0. Abort in IDLE is a no-op.
- i_Abort and i_Start in the same IDLE cycle: abort wins, no start.
- i_Start while busy: ignored.
- i_Reset mid-sweep: next cycle equals the reset state, and the generator is disabled.

Optional Feature:
Macro FREQ_SWEEP_CTRL_LOOP_EN.
- Defined: on reaching Stop, no DONE. The sweep restarts at the latched Start_HP with o_Load and o_Index=0, and repeats until i_Abort. o_Done never pulses.
- Undefined: single pass as above.

Decomposition:
- Shared package freq_pkg:
  - state encoding localparams (S_IDLE, S_DWELL, S_DONE)
  - MS_DIV derivation function
  - HP clamp helper
  - default CLK_HZ constant shared with generator and counter
- Sub-module ms_tick_gen: prescaler with sync clear, emitting a one-cycle 1 ms tick.
- Sequencer FSM stays in freq_sweep_ctrl.

Test Plan:
All scenarios use CLK_HZ=10_000 (MS_DIV=10).
1. Up sweep: Start=100, Stop=130, Step=10, Dwell=2.
   - o_Load at 4 points (100, 110, 120, 130) spaced 20 cycles.
   - o_Index 0..3; o_Done 20 cycles after last load; o_Gen_En low with o_Done.
2. Down sweep with clamp: Start=50, Stop=20, Step=12.
   - Points 50, 38, 26, 20, then o_Done.
3. Step=0 and Dwell=0: Start=7.
   - Single o_Load of 7; o_Done exactly 10 cycles later.
4. Error: Start=0 with i_Start.
   - o_Error=1, o_Busy stays 0, no o_Load.
   - Next valid start clears o_Error.
5. Abort/reset: i_Abort during point 2, and separately i_Reset mid-sweep.
   - Next cycle o_Busy=0, o_Gen_En=0, no o_Done.
   - i_Start while busy has no effect on point spacing.
6. With FREQ_SWEEP_CTRL_LOOP_EN, scenario 1 setup:
   - After 130, next o_Load=100 with o_Index=0; no o_Done over 3 passes.
   - i_Abort ends the sweep.
